// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud encodings, receiver states and divisor helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int          DIV_W      = 16;

  typedef enum logic [1:0] {
    BAUD24  = 2'b00,
    BAUD48  = 2'b01,
    BAUD96  = 2'b10,
    BAUD192 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,RX_PARITY = 3'd4
`endif
  } rx_state_e;

  // Rounded oversample divisor: round(clock_hz / (16 * baud)).
  function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clock_hz,
                                                    input logic [1:0] code);
    int unsigned baud;
    case (code)
      BAUD24:  baud = 2400;
      BAUD48:  baud = 4800;
      BAUD96:  baud = 9600;
      default: baud = 19200;
    endcase
    return DIV_W'((clock_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud));
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - 16x oversample prescaler; divisor latched on request, count held at 0 by clear.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 50_000_000
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       clear_i,
  input  logic       latch_i,
  input  logic [1:0] baud_i,
  output logic       tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign tick_o = !clear_i && (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    div_d = latch_i ? baud_divisor(CLOCK_HZ, baud_i) : div_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
      div_q <= baud_divisor(CLOCK_HZ, BAUD24);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchronizer, frame FSM and shift register, 8N1 by default.
// Defining UART_RX_PARITY_EN adds the parity_type port, PARITY state and parity checker.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [1:0] baud_rate,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0] parity_type,
`endif
  output logic [7:0] data_out,
  output logic       done,
  output logic       stop_error,
  output logic       parity_error,
  output logic       busy
);

  logic      rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e state_q, state_d;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [2:0] b_cnt_q, b_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       stop_err_q, stop_err_d;
  logic       tick, start_edge, sample;

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_mode_q, par_mode_d;
  logic       par_mis_q, par_mis_d;
  logic       par_err_q, par_err_d;
  logic       par_on, par_exp;

  assign par_on  = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign par_exp = (^shift_q) ^ (par_mode_q == 2'b01);
`endif

  assign start_edge = (state_q == RX_IDLE) && rx_prev_q && !rx_s_q;
  assign sample     = tick && (s_cnt_q == 4'd15);

  uart_rx_tick #(
    .CLOCK_HZ(CLOCK_HZ)
  ) u_tick (
    .clock_i (clock),
    .reset_ni(reset_n),
    .clear_i (state_q == RX_IDLE),
    .latch_i (start_edge),
    .baud_i  (baud_rate),
    .tick_o  (tick)
  );

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    b_cnt_d    = b_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    stop_err_d = stop_err_q;
`ifdef UART_RX_PARITY_EN
    par_mode_d = par_mode_q;
    par_mis_d  = par_mis_q;
    par_err_d  = par_err_q;
`endif
    if ((state_q != RX_IDLE) && tick) begin
      s_cnt_d = s_cnt_q + 4'd1;
    end

    case (state_q)
      RX_IDLE: begin
        if (start_edge) begin
          state_d = RX_START;
          s_cnt_d = '0;
          b_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_mode_d = parity_type;
          par_mis_d  = 1'b0;
`endif
        end
      end
      RX_START: begin
        // Mid start bit: a high line here was a glitch, not a frame.
        if (tick && (s_cnt_q == 4'd7)) begin
          if (!rx_s_q) begin
            s_cnt_d = '0;
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (sample) begin
          shift_d[b_cnt_q] = rx_s_q;
          b_cnt_d          = b_cnt_q + 3'd1;
          if (b_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_on ? RX_PARITY : RX_STOP;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (sample) begin
          par_mis_d = rx_s_q ^ par_exp;
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (sample) begin
          done_d     = 1'b1;
          data_d     = shift_q;
          stop_err_d = !rx_s_q;
`ifdef UART_RX_PARITY_EN
          par_err_d  = par_mis_q;
`endif
          state_d    = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= RX_IDLE;
      s_cnt_q    <= '0;
      b_cnt_q    <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      stop_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mode_q <= '0;
      par_mis_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      b_cnt_q    <= b_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      stop_err_q <= stop_err_d;
`ifdef UART_RX_PARITY_EN
      par_mode_q <= par_mode_d;
      par_mis_q  <= par_mis_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign done       = done_q;
  assign stop_error = stop_err_q;
  assign busy       = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error = par_err_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at a reduced 2 MHz clock.
// Parity scenarios are built when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] baud_rate = 2'b10;
`ifdef UART_RX_PARITY_EN
  logic [1:0] parity_type = 2'b00;
`endif
  logic [7:0] data_out;
  logic       done, stop_error, parity_error, busy;

  typedef struct {
    logic [7:0] data;
    logic       stop_err;
    logic       par_err;
    int         fall_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  uart_rx #(.CLOCK_HZ(2_000_000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .baud_rate   (baud_rate),
`ifdef UART_RX_PARITY_EN
    .parity_type (parity_type),
`endif
    .data_out    (data_out),
    .done        (done),
    .stop_error  (stop_error),
    .parity_error(parity_error),
    .busy        (busy)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Divisors at 2 MHz: round(2e6 / (16 * baud)).
  function automatic int model_div(input logic [1:0] code);
    case (code)
      2'b00:   return 52;
      2'b01:   return 26;
      2'b10:   return 13;
      default: return 7;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (prev_done !== 1'b0) begin
          errors++;
          $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: data_out=%h with empty scoreboard", data_out);
        end else begin
          mon_e = sb.pop_front();
          if (data_out !== mon_e.data) begin
            errors++;
            $display("FAIL data_out: got %h expected %h", data_out, mon_e.data);
          end
          checks++;
          if (stop_error !== mon_e.stop_err) begin
            errors++;
            $display("FAIL stop_error: got %b expected %b (data %h)", stop_error, mon_e.stop_err, mon_e.data);
          end
          checks++;
          if (parity_error !== mon_e.par_err) begin
            errors++;
            $display("FAIL parity_error: got %b expected %b (data %h)", parity_error, mon_e.par_err, mon_e.data);
          end
          checks++;
          if ((cyc - mon_e.fall_cyc) !== mon_e.lat) begin
            errors++;
            $display("FAIL done_latency: got %0d expected %0d (data %h)", cyc - mon_e.fall_cyc, mon_e.lat, mon_e.data);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] code, input logic has_par,
                            input logic par_bit, input logic stop_bit, input logic pe);
    int div, p;
    div = model_div(code);
    p = 16 * div;
    baud_rate = code;
    sb.push_back('{data: d, stop_err: !stop_bit, par_err: pe, fall_cyc: cyc,
                   lat: (has_par ? 168 : 152) * div + 3});
    rx = 1'b0;
    idle(p / 2);
    baud_rate = ~code;
    idle(p - p / 2);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(p);
    end
    if (has_par) begin
      rx = par_bit;
      idle(p);
    end
    rx = stop_bit;
    idle(p);
    rx = 1'b1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20000 && done_cnt < target; i++) @(negedge clock);
    idle(4);
    checks++;
    if (done_cnt !== target) begin
      errors++;
      $display("FAIL done_count: got %0d expected %0d", done_cnt, target);
    end
  endtask

  task automatic test_reset;
    idle(5);
    reset_n = 1'b1;
    idle(1);
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (stop_error !== 1'b0) begin errors++; $display("FAIL reset_stop_error: got %b expected 0", stop_error); end
    checks++;
    if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int n;
    n = done_cnt;
    send_frame(8'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(n + 1);
  endtask

  task automatic test_parity;
    int n;
    n = done_cnt;
    idle(20);
`ifdef UART_RX_PARITY_EN
    parity_type = 2'b10;
    send_frame(8'hA3, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1 != ^(8'hA3));
    idle(20);
    send_frame(8'hA3, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0 != ^(8'hA3));
    idle(20);
    parity_type = 2'b01;
    send_frame(8'hA3, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0 != !(^(8'hA3)));
    idle(20);
    parity_type = 2'b00;
    wait_done(n + 3);
`else
    send_frame(8'hA3, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(n + 1);
`endif
  endtask

  task automatic test_stop_error;
    int n;
    n = done_cnt;
    idle(20);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(n + 1);
    idle(832);
    checks++;
    if (stop_error !== 1'b1) begin errors++; $display("FAIL stop_error_hold: got %b expected 1", stop_error); end
    send_frame(8'h3D, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(n + 2);
  endtask

  task automatic test_false_start;
    int n, c0, t_fall;
    logic fell;
    n = done_cnt;
    fell = 1'b0;
    t_fall = 0;
    idle(20);
    baud_rate = 2'b01;
    c0 = cyc;
    rx = 1'b0;
    idle(4 * 26);
    rx = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_high: got %b expected 1", busy); end
    for (int i = 0; i < 2000 && !fell; i++) begin
      @(posedge clock);
      #1;
      if (busy === 1'b0) begin
        fell = 1'b1;
        t_fall = cyc;
      end
    end
    @(negedge clock);
    checks++;
    if (!fell || (t_fall - c0) !== 8 * 26 + 3) begin
      errors++;
      $display("FAIL false_start_busy_fall: got cycle %0d (fell=%b) expected %0d", t_fall - c0, fell, 8 * 26 + 3);
    end
    idle(2 * 16 * 26);
    checks++;
    if (done_cnt !== n) begin errors++; $display("FAIL false_start_done: got %0d strobes expected %0d", done_cnt, n); end
    checks++;
    if (data_out !== 8'h3D) begin errors++; $display("FAIL false_start_data: got %h expected 3d", data_out); end
    checks++;
    if (stop_error !== 1'b0) begin errors++; $display("FAIL false_start_stop_error: got %b expected 0", stop_error); end
  endtask

  task automatic test_back_to_back;
    int n;
    n = done_cnt;
    idle(20);
    send_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(n + 2);
  endtask

  task automatic test_reset_midframe;
    int n, p;
    logic [7:0] d;
    d = 8'hF8;
    p = 16 * model_div(2'b10);
    n = done_cnt;
    idle(20);
    baud_rate = 2'b10;
    rx = 1'b0;
    idle(p);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      idle(p);
    end
    rx = d[3];
    idle(p / 2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data_out: got %h expected 00", data_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++;
    if (stop_error !== 1'b0 || parity_error !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got stop=%b par=%b done=%b expected 0 0 0", stop_error, parity_error, done);
    end
    rx = 1'b1;
    idle(4 * p);
    checks++;
    if (done_cnt !== n) begin errors++; $display("FAIL midreset_done: got %0d strobes expected %0d", done_cnt, n); end
    send_frame(8'h81, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(n + 1);
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_basic;
    test_parity;
    test_stop_error;
    test_false_start;
    test_back_to_back;
    test_reset_midframe;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver for the UART, paired with the existing transmitter and its baud generator.
- Recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) from the asynchronous `rx` line.
- Uses an internal 16x-oversampling tick generator driven from the 50 MHz system clock, with the same 2-bit baud select as the Tx side.
- Presents each received byte with a one-cycle `done` strobe plus framing and parity status.

## Interface
- `CLOCK_HZ`, 50_000_000, system clock frequency used for divisor computation.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `baud_rate`  in  2  00=2400, 01=4800, 10=9600, 11=19200.
- `parity_type`  in  2  present only with `UART_RX_PARITY_EN`: 00/11 none, 01 odd, 10 even.
- `data_out`  out  8  last received byte.
- `done`  out  1  one-cycle strobe: `data_out` and the status flags are updated.
- `stop_error`  out  1  stop bit sampled low in last frame.
- `parity_error`  out  1  parity mismatch in last frame (constant 0 without macro).
- `busy`  out  1  high while not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1. All logic uses the synchronized value `rx_s`.
- Oversample divisor: div = round(CLOCK_HZ / (16 × baud)). At defaults this gives 1302 / 651 / 326 / 163.
  - The tick counter counts 0..div-1 and emits `tick` when count == div-1.
- In IDLE the prescaler is held at 0 and `baud_rate` is sampled continuously. The divisor is latched on start detection, so `baud_rate` changes mid-frame are ignored.
- Sample counter `s_cnt` is 4 bits and wraps 15→0. Bit counter `b_cnt` is 3 bits.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on `rx_s` (previous 1, current 0) goes to START and clears the prescaler, `s_cnt` and `b_cnt`.
  - START: on the tick where `s_cnt` == 7 (mid start bit):
    - `rx_s` == 0: clear `s_cnt`, go to DATA.
    - `rx_s` == 1: false start; return to IDLE with no `done`.
  - DATA: on each tick where `s_cnt` == 15, shift `rx_s` into bit[`b_cnt`] (LSB first) and increment `b_cnt`.
    - After bit 7, go to PARITY if parity is enabled and selected; otherwise go to STOP.
  - PARITY: sample at `s_cnt` == 15 and compare against XOR of the data bits (even) or its inverse (odd).
  - STOP: sample at `s_cnt` == 15, then return to IDLE in the same transition. This allows back-to-back frames with a start edge detected immediately after.
- Next cycle after the stop sample:
  - `done` = 1.
  - `data_out` = shift register.
  - `stop_error` = !stop_sample.
  - `parity_error` = mismatch.
  - Data is delivered even on error.
- The flags hold until the next `done`.
- Reset mid-frame returns to IDLE and clears all outputs. The next full frame is received normally.

## Timing
- Reset values: `data_out`=0, `done`=0, `stop_error`=0, `parity_error`=0, `busy`=0.
- Start edge is seen 2 cycles after the `rx` pin falls (synchronizer). `busy` rises the cycle after.
- Sample points, measured in ticks after start detection:
  - start check: 8
  - data bit k: 24+16k
  - parity: 152
  - stop: 152 (no parity) or 168 (parity)
- `done` asserts exactly 1 cycle after the stop-sample tick and lasts exactly 1 cycle.
- `busy` falls in the same cycle `done` rises.
- `tick` is never generated in IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - `parity_type` port exists.
  - PARITY state and checker are built.
- Not defined:
  - No `parity_type` port and no PARITY state.
  - `parity_error` is tied to 0.
  - Frame is always 8N1.

## Structure
- Shared package `uart_pkg`:
  - baud encodings BAUD24/48/96/192
  - receiver state encoding
  - `OVERSAMPLE`=16
  - divisor function of (`CLOCK_HZ`, baud code)
- Sub-module `uart_rx_tick`: prescaler with latch-divisor and clear inputs, `tick` output.
- Synchronizer, FSM and shift register live in `uart_rx`.

## Test plan
- 0x55 at 9600, 8N1, ideal timing → exactly one `done`, `data_out`=0x55, both errors 0. `done` lands 152×326+3 cycles after the pin falls.
- 0xA3 at 19200, even parity, parity bit driven 1 (correct is 0) → `done`, `data_out`=0xA3, `parity_error`=1, `stop_error`=0. Same with parity bit 0 → `parity_error`=0.
- 0x3C at 2400 with stop bit driven 0 → `data_out`=0x3C, `stop_error`=1. Next good frame 0x3D → `stop_error` clears to 0.
- `rx` low pulse of 4 oversample ticks at 4800 → no `done`, `busy` returns to 0 at tick 8, outputs unchanged.
- Back-to-back 0x00 then 0xFF at 19200, second start bit immediately after the first stop bit → two `done` strobes with the correct bytes, no errors.
- Assert `reset_n`=0 for 1 cycle during data bit 3 → all outputs 0, `busy`=0. A following 0x81 frame → `data_out`=0x81.
